// File: rtl/hash_pkg.sv
// Shared constants, state type and helpers for the SHA-256 block packer.
package hash_pkg;

  localparam int SHA_BLOCK_W = 512;
  localparam int SHA_LEN_W   = 64;

  // 0x80 marker left-aligned in a 64-bit word; narrower beats take the top bits.
  localparam logic [63:0] SHA_PAD_MARKER = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    PADBLK
  } packer_state_t;

  // True when a marker in slot 'used' still leaves room for the 64-bit length.
  function automatic logic fits_len(input int unsigned used, input int unsigned width);
    return ((used + 32'd1) * width) <= 32'(SHA_BLOCK_W - SHA_LEN_W);
  endfunction

endpackage

// File: rtl/sha256_block_packer_pad_fmt.sv
// Combinational padding formatter for the SHA-256 block packer.
// Masks unused beat slots, places the 0x80 marker and the bit length, and
// reports what padding is still owed to a follow-on block.
// Build option: HASH_PAD_EN (undefined = raw packing, zero fill only).
module sha256_pad_fmt
  import hash_pkg::*;
#(
  parameter int AXI_WIDTH = 64,
  parameter int IDX_W     = 4
) (
  input  logic [SHA_BLOCK_W-1:0] blk_in,
  input  logic [IDX_W-1:0]       used,
  input  logic [SHA_LEN_W-1:0]   len,
  input  logic                   pad_only,
  input  logic                   marker_pend_in,
  output logic [SHA_BLOCK_W-1:0] blk_out,
  output logic                   last_out,
  output logic                   marker_pend_out,
  output logic                   len_pend_out
);

  localparam int BEATS = SHA_BLOCK_W / AXI_WIDTH;

  logic [SHA_BLOCK_W-1:0] masked;

  // Keep only the slots that hold accepted beats; everything after is zero.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_mask
      assign masked[SHA_BLOCK_W-1-gi*AXI_WIDTH -: AXI_WIDTH] =
        (IDX_W'(gi) < used) ? blk_in[SHA_BLOCK_W-1-gi*AXI_WIDTH -: AXI_WIDTH] : '0;
    end
  endgenerate

`ifdef HASH_PAD_EN
  logic                   marker_here;
  logic                   len_here;
  logic [SHA_BLOCK_W-1:0] marked;

  // A padding-only block carries the marker only if it was deferred.
  assign marker_here = pad_only ? marker_pend_in : (used != IDX_W'(BEATS));
  assign len_here    = fits_len(32'(used), 32'(AXI_WIDTH));

  // Drop the marker into the first free slot.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_mark
      assign marked[SHA_BLOCK_W-1-gi*AXI_WIDTH -: AXI_WIDTH] =
        (marker_here && (used == IDX_W'(gi))) ? SHA_PAD_MARKER[63 -: AXI_WIDTH]
                                              : masked[SHA_BLOCK_W-1-gi*AXI_WIDTH -: AXI_WIDTH];
    end
  endgenerate

  assign blk_out         = len_here ? {marked[SHA_BLOCK_W-1:SHA_LEN_W], len} : marked;
  assign last_out        = len_here;
  assign marker_pend_out = !len_here && !marker_here;
  assign len_pend_out    = !len_here;
`else
  logic unused_ok;

  assign blk_out         = masked;
  assign last_out        = 1'b1;
  assign marker_pend_out = 1'b0;
  assign len_pend_out    = 1'b0;
  assign unused_ok       = ^{len, pad_only, marker_pend_in};
`endif

endmodule

// File: rtl/sha256_block_packer.sv
// SHA-256 block packer: packs AXI weight beats into 512-bit message blocks
// (first beat most significant) and appends SHA-256 padding after s_last.
// Build option: HASH_PAD_EN (undefined = raw packing, no marker/length).
module sha256_block_packer
  import hash_pkg::*;
#(
  parameter int AXI_WIDTH = 64,
  parameter int LEN_W     = SHA_LEN_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [AXI_WIDTH-1:0]   s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [SHA_BLOCK_W-1:0] m_block,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_first,
  output logic                   m_last,
  output logic [LEN_W-1:0]       msg_bits,
  output logic                   busy
);

  localparam int BEATS = SHA_BLOCK_W / AXI_WIDTH;
  localparam int IDX_W = $clog2(BEATS) + 1;

  packer_state_t          state_reg;
  logic [SHA_BLOCK_W-1:0] blk_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [LEN_W-1:0]       msg_bits_reg;
  logic                   busy_reg;
  logic                   s_ready_reg;
  logic                   m_valid_reg;
  logic                   m_first_reg;
  logic                   m_last_reg;
  logic                   first_pend_reg;
  logic                   marker_pend_reg;
  logic                   len_pend_reg;

  logic                   accept;
  logic                   pad_only;
  logic                   block_full;
  logic [IDX_W-1:0]       used_next;
  logic [LEN_W-1:0]       bits_next;
  logic [SHA_BLOCK_W-1:0] blk_merged;
  logic [SHA_BLOCK_W-1:0] fmt_blk_in;
  logic [IDX_W-1:0]       fmt_used;
  logic [SHA_LEN_W-1:0]   fmt_len;
  logic [SHA_BLOCK_W-1:0] fmt_blk;
  logic                   fmt_last;
  logic                   fmt_marker_pend;
  logic                   fmt_len_pend;

  // s_ready is only ever high in FILL, so this is the beat handshake.
  assign accept     = s_valid && s_ready_reg;
  assign pad_only   = (state_reg == PADBLK);
  assign used_next  = idx_reg + IDX_W'(1);
  assign block_full = (used_next == IDX_W'(BEATS));
  assign bits_next  = msg_bits_reg + LEN_W'(AXI_WIDTH);

  // Current block with the incoming beat written into its slot.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_merge
      assign blk_merged[SHA_BLOCK_W-1-gi*AXI_WIDTH -: AXI_WIDTH] =
        (idx_reg == IDX_W'(gi)) ? s_data : blk_reg[SHA_BLOCK_W-1-gi*AXI_WIDTH -: AXI_WIDTH];
    end
  endgenerate

  // The padding-only block is formatted from an empty block and the final length.
  assign fmt_blk_in = pad_only ? '0 : blk_merged;
  assign fmt_used   = pad_only ? '0 : used_next;
  assign fmt_len    = pad_only ? msg_bits_reg : bits_next;

  sha256_pad_fmt #(
    .AXI_WIDTH (AXI_WIDTH),
    .IDX_W     (IDX_W)
  ) u_pad_fmt (
    .blk_in          (fmt_blk_in),
    .used            (fmt_used),
    .len             (fmt_len),
    .pad_only        (pad_only),
    .marker_pend_in  (marker_pend_reg),
    .blk_out         (fmt_blk),
    .last_out        (fmt_last),
    .marker_pend_out (fmt_marker_pend),
    .len_pend_out    (fmt_len_pend)
  );

  // Packer FSM: fill beats, emit blocks, and add a padding-only block when owed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= FILL;
      blk_reg         <= '0;
      idx_reg         <= '0;
      msg_bits_reg    <= '0;
      busy_reg        <= 1'b0;
      s_ready_reg     <= 1'b0;
      m_valid_reg     <= 1'b0;
      m_first_reg     <= 1'b0;
      m_last_reg      <= 1'b0;
      first_pend_reg  <= 1'b1;
      marker_pend_reg <= 1'b0;
      len_pend_reg    <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          s_ready_reg <= 1'b1;
          if (accept) begin
            blk_reg      <= blk_merged;
            idx_reg      <= used_next;
            msg_bits_reg <= bits_next;
            busy_reg     <= 1'b1;
            if (s_last || block_full) begin
              state_reg      <= EMIT;
              s_ready_reg    <= 1'b0;
              m_valid_reg    <= 1'b1;
              m_first_reg    <= first_pend_reg;
              first_pend_reg <= 1'b0;
              if (s_last) begin
                blk_reg         <= fmt_blk;
                m_last_reg      <= fmt_last;
                marker_pend_reg <= fmt_marker_pend;
                len_pend_reg    <= fmt_len_pend;
              end else begin
                m_last_reg <= 1'b0;
              end
            end
          end
        end

        EMIT: begin
          if (m_ready) begin
            m_valid_reg <= 1'b0;
            m_first_reg <= 1'b0;
`ifdef HASH_PAD_EN
            if (marker_pend_reg || len_pend_reg) begin
              state_reg <= PADBLK;
            end else
`endif
            begin
              state_reg   <= FILL;
              s_ready_reg <= 1'b1;
              idx_reg     <= '0;
              m_last_reg  <= 1'b0;
              if (m_last_reg) begin
                msg_bits_reg   <= '0;
                busy_reg       <= 1'b0;
                first_pend_reg <= 1'b1;
              end
            end
          end
        end

`ifdef HASH_PAD_EN
        PADBLK: begin
          state_reg       <= EMIT;
          blk_reg         <= fmt_blk;
          m_valid_reg     <= 1'b1;
          m_first_reg     <= first_pend_reg;
          first_pend_reg  <= 1'b0;
          m_last_reg      <= fmt_last;
          marker_pend_reg <= fmt_marker_pend;
          len_pend_reg    <= fmt_len_pend;
        end
`endif

        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_reg;
  assign m_block  = blk_reg;
  assign m_valid  = m_valid_reg;
  assign m_first  = m_first_reg;
  assign m_last   = m_last_reg;
  assign msg_bits = msg_bits_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_sha256_block_packer.sv
// Testbench for sha256_block_packer (AXI_WIDTH=64). Follows HASH_PAD_EN.
module tb_sha256_block_packer;

  localparam int AW = 64;

  logic         clk = 1'b0;
  logic         rstn;
  logic [AW-1:0] s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [511:0] m_block;
  logic         m_valid;
  logic         m_ready;
  logic         m_first;
  logic         m_last;
  logic [63:0]  msg_bits;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sha256_block_packer #(
    .AXI_WIDTH (AW),
    .LEN_W     (64)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_block  (m_block),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_first  (m_first),
    .m_last   (m_last),
    .msg_bits (msg_bits),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"},  512'(s_ready), 512'(0));
    chk({tag, "_m_valid"},  512'(m_valid), 512'(0));
    chk({tag, "_m_first"},  512'(m_first), 512'(0));
    chk({tag, "_m_last"},   512'(m_last), 512'(0));
    chk({tag, "_m_block"},  m_block, 512'(0));
    chk({tag, "_msg_bits"}, 512'(msg_bits), 512'(0));
    chk({tag, "_busy"},     512'(busy), 512'(0));
  endtask

  // Send one n-beat message with random gaps; hold m_ready low for 'stall'
  // cycles on the first block. Expected blocks come from a word-level model of
  // the padded message stream.
  task automatic run_msg(input int n, input int stall, input string name);
    logic [63:0]  beats[$];
    logic [63:0]  words[$];
    logic [511:0] exp_blk;
    int nblk, sent, got, cyc, stall_left, covered;
    logic go_valid, go_ready;

    for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
    for (int i = 0; i < n; i++) words.push_back(beats[i]);
`ifdef HASH_PAD_EN
    words.push_back(64'h8000_0000_0000_0000);
    while (words.size() % 8 != 7) words.push_back(64'd0);
    words.push_back(64'(n) * 64'd64);
`else
    while (words.size() % 8 != 0) words.push_back(64'd0);
`endif
    nblk = words.size() / 8;

    sent = 0; got = 0; cyc = 0; stall_left = stall;
    while (got < nblk && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      go_valid = (sent < n) && ($urandom_range(0, 3) != 0);
      s_valid  = go_valid;
      s_data   = (sent < n) ? beats[sent] : 64'd0;
      s_last   = go_valid && (sent == n - 1);
      if (m_valid) begin
        for (int k = 0; k < 8; k++) exp_blk[511-64*k -: 64] = words[8*got+k];
        covered = (8 * (got + 1) < n) ? 8 * (got + 1) : n;
        chk({name, "_block"},    m_block, exp_blk);
        chk({name, "_first"},    512'(m_first), 512'(got == 0));
        chk({name, "_last"},     512'(m_last), 512'(got == nblk - 1));
        chk({name, "_msg_bits"}, 512'(msg_bits), 512'(64'(covered) * 64'd64));
        chk({name, "_s_ready"},  512'(s_ready), 512'(0));
        chk({name, "_busy"},     512'(busy), 512'(1));
        if (stall_left > 0) begin
          go_ready = 1'b0;
          stall_left--;
        end else begin
          go_ready = 1'b1;
        end
      end else begin
        go_ready = ($urandom_range(0, 1) == 1);
      end
      m_ready = go_ready;
      if (go_valid && s_ready) sent++;
      if (m_valid && go_ready) got++;
    end
    chk({name, "_blocks_seen"}, 512'(got), 512'(nblk));
    chk({name, "_beats_taken"}, 512'(sent), 512'(n));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    chk({name, "_idle_busy"},     512'(busy), 512'(0));
    chk({name, "_idle_msg_bits"}, 512'(msg_bits), 512'(0));
    chk({name, "_idle_m_valid"},  512'(m_valid), 512'(0));
    $display("msg %s: %0d beats, %0d blocks", name, n, nblk);
  endtask

  initial begin
    int sent, cyc;
    rstn    = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rstn = 1'b1;

    run_msg(3, 0, "three_beats");
    run_msg(7, 0, "seven_beats");
    run_msg(8, 0, "eight_beats");
    run_msg(3, 5, "stall_emit");
    run_msg(6, 0, "six_beats");
    run_msg(9, 2, "nine_beats");

    // Four beats of an unfinished message, then an asynchronous reset mid-cycle.
    sent = 0; cyc = 0;
    while (sent < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      s_valid = 1'b1;
      s_data  = {$urandom, $urandom};
      s_last  = 1'b0;
      if (s_ready) sent++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("partial_busy",     512'(busy), 512'(1));
    chk("partial_msg_bits", 512'(msg_bits), 512'(256));
    #2 rstn = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    run_msg(2, 0, "after_reset");

    for (int t = 0; t < 12; t++) begin
      run_msg(int'($urandom_range(1, 24)), int'($urandom_range(0, 3)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
